// File: rtl/oldland_arb_pkg.sv
// Shared state encoding and grant identifiers for the oldland memory arbiter.
package oldland_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b001,
    ST_GRANT_I = 3'b010,
    ST_GRANT_D = 3'b100
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } arb_grant_e;

  // Counter must be at least one bit even for a zero timeout.
  function automatic int timer_width(input int cycles);
    return ($clog2(cycles + 1) < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/oldland_arb_timer.sv
// Bus-stall watchdog: counts enabled cycles, flags one cycle at the limit and
// restarts from zero.
module oldland_arb_timer
  import oldland_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW    = timer_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || expired)
      cnt_d = '0;
    else if (enable)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/oldland_mem_arbiter.sv
// Two-port (instruction fill / data) arbiter onto a single word-addressed
// memory bus with round-robin tie break, burst lock and a stall timeout.
module oldland_mem_arbiter
  import oldland_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_access,
  input  logic [29:0] i_addr,
  output logic [31:0] i_data,
  output logic        i_ack,
  output logic        i_error,
  input  logic        d_access,
  input  logic [29:0] d_addr,
  input  logic        d_wr_en,
  input  logic [3:0]  d_bytesel,
  input  logic [31:0] d_wr_val,
  output logic [31:0] d_data,
  output logic        d_ack,
  output logic        d_error,
  output logic        m_access,
  output logic [29:0] m_addr,
  output logic        m_wr_en,
  output logic [3:0]  m_bytesel,
  output logic [31:0] m_wr_val,
  input  logic [31:0] m_data,
  input  logic        m_ack,
  input  logic        m_error
);

  arb_state_e state_q, state_d;
  arb_grant_e last_q, last_d;
  logic       gnt_i, gnt_d, granted, expired;

  assign gnt_i   = (state_q == ST_GRANT_I);
  assign gnt_d   = (state_q == ST_GRANT_D);
  assign granted = gnt_i | gnt_d;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_access && d_access) begin
          // Tie goes to whoever was not served last.
          state_d = (last_q == GNT_I) ? ST_GRANT_D : ST_GRANT_I;
          last_d  = (last_q == GNT_I) ? GNT_D : GNT_I;
        end else if (i_access) begin
          state_d = ST_GRANT_I;
          last_d  = GNT_I;
        end else if (d_access) begin
          state_d = ST_GRANT_D;
          last_d  = GNT_D;
        end
      end
      ST_GRANT_I: if (!i_access) state_d = ST_IDLE;
      ST_GRANT_D: if (!d_access) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= GNT_I;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    m_access  = 1'b0;
    m_addr    = '0;
    m_wr_en   = 1'b0;
    m_bytesel = 4'b0000;
    m_wr_val  = '0;
    if (gnt_i) begin
      m_access  = i_access;
      m_addr    = i_addr;
      m_bytesel = 4'b1111;
    end else if (gnt_d) begin
      m_access  = d_access;
      m_addr    = d_addr;
      m_wr_en   = d_wr_en;
      m_bytesel = d_bytesel;
      m_wr_val  = d_wr_val;
    end
  end

  assign i_data  = m_data;
  assign d_data  = m_data;
  assign i_ack   = gnt_i & m_ack;
  assign d_ack   = gnt_d & m_ack;
  assign i_error = gnt_i & (m_error | expired);
  assign d_error = gnt_d & (m_error | expired);

  // Held at zero outside a grant, so every grant starts counting from zero.
  oldland_arb_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (~granted | m_ack | m_error),
    .enable  (granted & m_access & ~m_ack & ~m_error),
    .expired (expired)
  );

endmodule

// File: tb/tb_oldland_mem_arbiter.sv
// Directed bench for oldland_mem_arbiter; inputs change on negedge, outputs
// are checked 1ns later, state advances on posedge.
module tb_oldland_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_access, d_access, d_wr_en, m_ack, m_error;
  logic [29:0] i_addr, d_addr, m_addr;
  logic [3:0]  d_bytesel, m_bytesel;
  logic [31:0] d_wr_val, m_data, i_data, d_data, m_wr_val;
  logic        i_ack, i_error, d_ack, d_error, m_access, m_wr_en;

  int n_chk  = 0;
  int n_fail = 0;
  int acks;

  always #5 clk = ~clk;

  oldland_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .i_access(i_access), .i_addr(i_addr), .i_data(i_data), .i_ack(i_ack), .i_error(i_error),
    .d_access(d_access), .d_addr(d_addr), .d_wr_en(d_wr_en), .d_bytesel(d_bytesel),
    .d_wr_val(d_wr_val), .d_data(d_data), .d_ack(d_ack), .d_error(d_error),
    .m_access(m_access), .m_addr(m_addr), .m_wr_en(m_wr_en), .m_bytesel(m_bytesel),
    .m_wr_val(m_wr_val), .m_data(m_data), .m_ack(m_ack), .m_error(m_error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    settle();
    step();
    rst = 1'b0;
  endtask

  task automatic quiet(input string tag);
    chk({tag, ".i_ack"},   32'(i_ack),   32'd0);
    chk({tag, ".d_ack"},   32'(d_ack),   32'd0);
    chk({tag, ".i_error"}, 32'(i_error), 32'd0);
    chk({tag, ".d_error"}, 32'(d_error), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    i_access = 1'b1; d_access = 1'b1; d_wr_en = 1'b1; m_ack = 1'b1; m_error = 1'b1;
    i_addr = 30'h100; d_addr = 30'h2000; d_bytesel = 4'b0011; d_wr_val = 32'hDEADBEEF;
    m_data = 32'h0;

    // Reset state with every request input active
    settle();
    chk("rst.m_access", 32'(m_access), 32'd0);
    chk("rst.m_wr_en",  32'(m_wr_en),  32'd0);
    quiet("rst");
    step();
    i_access = 1'b0; d_access = 1'b0; d_wr_en = 1'b0; m_ack = 1'b0; m_error = 1'b0;
    rst = 1'b0;
    settle();
    chk("post_rst.m_access", 32'(m_access), 32'd0);
    quiet("post_rst");

    // I burst, 8 acks
    i_access = 1'b1;
    settle();
    chk("i_burst.idle_m_access", 32'(m_access), 32'd0);
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      m_ack = 1'b1; m_data = 32'hA000_0000 + 32'(k);
      settle();
      chk("i_burst.m_access", 32'(m_access), 32'd1);
      if (k == 0) begin
        chk("i_burst.m_addr",    32'(m_addr),    32'h100);
        chk("i_burst.m_wr_en",   32'(m_wr_en),   32'd0);
        chk("i_burst.m_bytesel", 32'(m_bytesel), 32'hF);
      end
      chk("i_burst.i_data", i_data, 32'hA000_0000 + 32'(k));
      chk("i_burst.d_ack", 32'(d_ack), 32'd0);
      if (i_ack) acks++;
    end
    chk("i_burst.ack_count", 32'(acks), 32'd8);
    step();
    i_access = 1'b0; m_ack = 1'b0;
    settle();
    chk("i_burst.release_m_access", 32'(m_access), 32'd0);

    // Tie from reset: D first, then one IDLE cycle, then I
    do_reset();
    i_access = 1'b1; d_access = 1'b1; d_wr_en = 1'b0; i_addr = 30'h111; d_addr = 30'h222;
    settle();
    chk("tie.idle_m_access", 32'(m_access), 32'd0);
    step();
    m_ack = 1'b1;
    settle();
    chk("tie.d_first_addr", 32'(m_addr), 32'h222);
    chk("tie.d_ack", 32'(d_ack), 32'd1);
    chk("tie.i_ack_masked", 32'(i_ack), 32'd0);
    step();
    d_access = 1'b0;   // ack arrives as access drops
    settle();
    chk("tie.ack_on_drop", 32'(d_ack), 32'd1);
    step();
    settle();
    chk("tie.idle_gap_m_access", 32'(m_access), 32'd0);
    chk("tie.idle_gap_i_ack", 32'(i_ack), 32'd0);
    step();
    settle();
    chk("tie.i_second_addr", 32'(m_addr), 32'h111);
    chk("tie.i_ack", 32'(i_ack), 32'd1);
    step();
    i_access = 1'b0; m_ack = 1'b0;

    // Data write mirrored on the bus until ack
    step();
    d_access = 1'b1; d_wr_en = 1'b1; d_addr = 30'h2000; d_bytesel = 4'b0011; d_wr_val = 32'hDEADBEEF;
    settle();
    chk("wr.idle_m_wr_en", 32'(m_wr_en), 32'd0);
    step();
    settle();
    chk("wr.m_access",  32'(m_access),  32'd1);
    chk("wr.m_wr_en",   32'(m_wr_en),   32'd1);
    chk("wr.m_addr",    32'(m_addr),    32'h2000);
    chk("wr.m_bytesel", 32'(m_bytesel), 32'h3);
    chk("wr.m_wr_val",  m_wr_val,       32'hDEADBEEF);
    chk("wr.no_ack_yet", 32'(d_ack),    32'd0);
    step();
    m_ack = 1'b1; m_data = 32'h1234_5678;
    settle();
    chk("wr.d_ack",  32'(d_ack), 32'd1);
    chk("wr.d_data", d_data,     32'h1234_5678);
    chk("wr.i_data", i_data,     32'h1234_5678);
    step();
    d_access = 1'b0; d_wr_en = 1'b0; m_ack = 1'b0;

    // Timeout: 4 silent cycles, then one error pulse, grant kept
    step();
    d_access = 1'b1;
    step();
    for (int k = 1; k <= 6; k++) begin
      settle();
      chk($sformatf("to.d_error_c%0d", k), 32'(d_error), (k == 5) ? 32'd1 : 32'd0);
      chk($sformatf("to.m_access_c%0d", k), 32'(m_access), 32'd1);
      chk($sformatf("to.i_error_c%0d", k), 32'(i_error), 32'd0);
      step();
    end
    d_access = 1'b0;
    settle();
    chk("to.drop_d_error", 32'(d_error), 32'd0);
    step();
    settle();
    chk("to.idle_m_access", 32'(m_access), 32'd0);

    // Reset on the 3rd beat of an I burst
    i_access = 1'b1; i_addr = 30'h300; d_addr = 30'h400;
    step();
    m_ack = 1'b1;
    step();
    step();
    rst = 1'b1;
    settle();
    chk("rst_mid.m_access", 32'(m_access), 32'd0);
    chk("rst_mid.i_ack",    32'(i_ack),    32'd0);
    chk("rst_mid.i_error",  32'(i_error),  32'd0);
    step();
    rst = 1'b0; d_access = 1'b1;
    settle();
    chk("rst_mid.idle_m_access", 32'(m_access), 32'd0);
    step();
    settle();
    chk("rst_mid.tie_to_d", 32'(m_addr), 32'h400);
    chk("rst_mid.d_ack",    32'(d_ack),  32'd1);
    step();
    i_access = 1'b0; d_access = 1'b0; m_ack = 1'b0;

    // Bus ack/error while idle must go nowhere
    step();
    step();
    m_ack = 1'b1; m_error = 1'b1;
    settle();
    quiet("idle_ack");
    step();
    m_ack = 1'b0; m_error = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
